chunked_addsub_alu: RTL and testbench
=====================================

# chunked_addsub_alu

Multi-cycle, parametrised add/subtract/logic unit for the Y86-64 execute stage. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, rippling carry between slices through a register. This shortens the per-cycle carry chain compared with a full-width ripple adder. It produces the result plus the Y86 condition codes (ZF, SF, OF) and a carry/borrow flag, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 64: operand and result width in bits.
- CHUNK, 16: slice width per cycle. WIDTH % CHUNK must be 0; otherwise elaboration fails.
- NCH, WIDTH/CHUNK: derived slice count. It is not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- control  in  2  Y86 function code: 00 addq (A+B), 01 subq (A−B), 10 andq (A&B), 11 xorq (A^B).
- A  in  WIDTH  operand A, signed two's complement.
- B  in  WIDTH  operand B, signed two's complement.
- out_valid  out  1  result and flags are valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  result.
- cf  out  1  add: carry out of the MSB. sub: borrow (inverted carry out). Logic ops: 0.
- zf  out  1  S == 0.
- sf  out  1  S[WIDTH-1].
- overflow  out  1  signed overflow. Logic ops: 0.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE → BUSY when in_valid && in_ready at a rising edge. On that edge the unit:
  - latches A, B and control;
  - clears the slice index k to 0;
  - loads the carry register with 1 for subq, 0 otherwise.
- BUSY, on each edge, computes slice k:
  - For sub, the B slice is inverted.
  - For add/sub, slice = A_k + B'_k + carry_reg. The slice carry-out is written to carry_reg.
  - For logic ops, slice = A_k & B_k or A_k ^ B_k, and carry_reg is unused.
  - The slice result is written into bits [k*CHUNK +: CHUNK] of the result register, and k increments.
- After slice NCH−1 is written, the FSM goes BUSY → DONE, and the flags are registered from the complete result:
  - zf, sf as defined in the interface.
  - cf = final carry_reg for add, ~carry_reg for sub.
  - overflow (add) = (A[MSB] == B[MSB]) && (S[MSB] != A[MSB]).
  - overflow (sub) = (A[MSB] != B[MSB]) && (S[MSB] != A[MSB]).
- DONE → IDLE on the edge where out_ready is high. While waiting, S and all flags hold stable.
- There is no same-cycle turnaround: in_ready is low in DONE, so a new operation can be accepted at the earliest one cycle after handoff.
- Input changes while BUSY or DONE are ignored; only the latched operands are used.
- S and the flags keep their last values in IDLE until the next result is registered.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk):
  - state = IDLE, in_ready = 1, out_valid = 0;
  - S = 0, cf = zf = sf = overflow = 0;
  - k = 0, carry_reg = 0.
- Reset during BUSY or DONE abandons the operation; no result is emitted.
- Latency: the accept edge is E0. out_valid rises after edge E_NCH, i.e. NCH cycles later; for the defaults, 4 cycles.
- CHUNK == WIDTH gives a latency of 1 cycle.
- Throughput: one operation per NCH+2 cycles when out_ready is held high.
- in_ready is a function of state only, with no combinational path from in_valid. out_valid is also a function of state only, with no combinational path from out_ready.
- Flags are registered together with the last slice. They are never visible before out_valid.

## Test plan
- **Add with carry and zero:** addq A=1, B=0xFFFF_FFFF_FFFF_FFFF → S=0, zf=1, cf=1, sf=0, overflow=0. out_valid asserts exactly 4 cycles after the accept edge.
- **Positive add overflow:** addq A=0x7FFF_FFFF_FFFF_FFFF, B=1 → S=0x8000_0000_0000_0000, overflow=1, sf=1, cf=0, zf=0.
- **Subtract overflow and borrow:**
  - subq A=0x8000_0000_0000_0000, B=1 → S=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cf=0.
  - subq A=0, B=1 → S=all ones, cf=1, sf=1, overflow=0.
- **Logic ops:**
  - xorq A=B=0x1234_5678_9ABC_DEF0 → S=0, zf=1, cf=0, overflow=0.
  - andq A=0xFF00_FF00_FF00_FF00, B=0x0FF0_0FF0_0FF0_0FF0 → S=0x0F00_0F00_0F00_0F00.
- **Backpressure:** hold out_ready=0 for 3 cycles in DONE. S and the flags stay stable, in_ready=0, and A/B changes are ignored. Raise out_ready: back in IDLE next cycle, then a new operation is accepted.
- **Reset mid-operation:** assert rst after 2 slices of an addq. Outputs go to 0 and in_ready to 1 without a clock edge. Release rst and issue subq A=5, B=7 → S=0xFFFF_FFFF_FFFF_FFFE, cf=1, sf=1. Rerun the suite with CHUNK=64 (latency 1) and CHUNK=8 (latency 8).

Source files
------------

// File: rtl/chunked_addsub_alu.sv
// ----------------------------------------------------------------------------
// chunked_addsub_alu
//
// Multi-cycle add/subtract/logic unit for the Y86-64 execute stage. A WIDTH-bit
// operation is processed CHUNK bits per clock, least significant slice first.
// The carry between slices travels through a register, so each cycle has only
// a CHUNK-bit carry chain. Condition codes are registered together with the
// last slice.
//
// Parameters:
//   WIDTH  operand/result width (default 64)
//   CHUNK  slice width processed per cycle (default 16); WIDTH % CHUNK == 0
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands/control valid
//   in_ready   unit can accept (IDLE only)
//   control    00 addq, 01 subq, 10 andq, 11 xorq
//   A, B       operands, two's complement
//   out_valid  result/flags valid (DONE only)
//   out_ready  consumer accepts result
//   S          result
//   cf         add: carry out; sub: borrow; logic: 0
//   zf         S == 0
//   sf         S[WIDTH-1]
//   overflow   signed overflow; logic: 0
// ----------------------------------------------------------------------------
module chunked_addsub_alu #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             overflow
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunked_addsub_alu: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    // Operands and result are held as arrays of slices so slice k is a plain
    // index rather than a computed part-select.
    state_e                     state_q;
    op_e                        op_q;
    logic [NCH-1:0][CHUNK-1:0]  a_q;
    logic [NCH-1:0][CHUNK-1:0]  b_q;
    logic [NCH-1:0][CHUNK-1:0]  s_q;
    logic [KW-1:0]              k_q;
    logic                       carry_q;
    logic                       cf_q;
    logic                       zf_q;
    logic                       sf_q;
    logic                       ov_q;

    logic [CHUNK-1:0]           a_k;
    logic [CHUNK-1:0]           b_k;
    logic [CHUNK-1:0]           b_eff;
    logic [CHUNK:0]             sum_w;
    logic [CHUNK-1:0]           slice_d;
    logic [NCH-1:0][CHUNK-1:0]  s_d;
    logic                       carry_d;
    logic                       is_arith;
    logic                       a_msb;
    logic                       b_msb;
    logic                       s_msb;
    logic                       cf_d;
    logic                       ov_d;

    // Datapath for the slice currently addressed by k_q.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that is what keeps always_comb latch-free.
        slice_d  = '0;
        cf_d     = 1'b0;
        ov_d     = 1'b0;

        a_k      = a_q[k_q];
        b_k      = b_q[k_q];
        // Subtraction is A + ~B + 1; the +1 is the carry preloaded on accept.
        b_eff    = (op_q == OP_SUB) ? ~b_k : b_k;
        sum_w    = {1'b0, a_k} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
        carry_d  = sum_w[CHUNK];
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

        case (op_q)
            OP_ADD, OP_SUB: slice_d = sum_w[CHUNK-1:0];
            OP_AND:         slice_d = a_k & b_k;
            OP_XOR:         slice_d = a_k ^ b_k;
            default:        slice_d = '0;
        endcase

        // Full result as it will stand after this edge; the flags on the last
        // slice are derived from it.
        s_d      = s_q;
        s_d[k_q] = slice_d;

        a_msb    = a_q[NCH-1][CHUNK-1];
        b_msb    = b_q[NCH-1][CHUNK-1];
        s_msb    = s_d[NCH-1][CHUNK-1];

        case (op_q)
            OP_ADD: begin
                cf_d = carry_d;
                ov_d = (a_msb == b_msb) && (s_msb != a_msb);
            end
            OP_SUB: begin
                cf_d = ~carry_d;
                ov_d = (a_msb != b_msb) && (s_msb != a_msb);
            end
            default: begin
                cf_d = 1'b0;
                ov_d = 1'b0;
            end
        endcase
    end

    // NOTE: the control path and the visible datapath registers are reset
    // together so S and the flags read as zero straight out of reset; the
    // operand registers are reset as well so no X can reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            case (state_q)
                ST_IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake.
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= op_e'(control);
                        k_q     <= '0;
                        carry_q <= (control == OP_SUB);
                        state_q <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    s_q <= s_d;
                    if (is_arith) begin
                        carry_q <= carry_d;
                    end
                    k_q <= k_q + KW'(1);
                    if (k_q == KW'(NCH - 1)) begin
                        zf_q    <= (s_d == '0);
                        sf_q    <= s_msb;
                        cf_q    <= cf_d;
                        ov_q    <= ov_d;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs depend on state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign cf        = cf_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_chunked_addsub_alu.sv
// ----------------------------------------------------------------------------
// tb_chunked_addsub_alu
//
// Scoreboard bench for chunked_addsub_alu. The driver pushes the expected
// result of every accepted operation, computed with full-width arithmetic,
// into a queue; an independent monitor pops and compares whenever the DUT
// hands a result over. Set CHUNK to 64 or 8 to exercise other slice counts.
// ----------------------------------------------------------------------------
module tb_chunked_addsub_alu #(
    parameter int CHUNK = 16
);

    localparam int WIDTH = 64;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cf;
        logic             zf;
        logic             sf;
        logic             ov;
        int               acc_cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cf;
    logic             zf;
    logic             sf;
    logic             overflow;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   seen_valid = 0;
    bit   rand_bp = 0;

    chunked_addsub_alu #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cf        (cf),
        .zf        (zf),
        .sf        (sf),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference model: whole-word arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [1:0] op,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0]        u;
        logic signed [WIDTH:0] w;
        e.cf = 1'b0;
        e.ov = 1'b0;
        case (op)
            2'b00: begin
                u    = {1'b0, a} + {1'b0, b};
                e.s  = u[WIDTH-1:0];
                e.cf = u[WIDTH];
                w    = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
                e.ov = (w > $signed({2'b00, {(WIDTH-1){1'b1}}})) ||
                       (w < $signed({2'b11, {(WIDTH-1){1'b0}}}));
            end
            2'b01: begin
                e.s  = a - b;
                e.cf = (a < b);
                w    = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
                e.ov = (w > $signed({2'b00, {(WIDTH-1){1'b1}}})) ||
                       (w < $signed({2'b11, {(WIDTH-1){1'b0}}}));
            end
            2'b10:   e.s = a & b;
            default: e.s = a ^ b;
        endcase
        e.zf = (e.s == '0);
        e.sf = e.s[WIDTH-1];
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Waits (bounded) for in_ready, presents one operation, and records the
    // expectation once the accepting edge has passed.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready stayed low for %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        control  = op;
        A        = a;
        B        = b;
        @(posedge clk); #1;
        e = model(op, a, b);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        A        = rnd64();
        B        = rnd64();
        control  = 2'($urandom_range(0, 3));
        check("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: latency on first sight of out_valid, compare on handoff.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                seen_valid = 0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: out_valid with empty scoreboard, S=%h", S);
                end else begin
                    e = exp_q[0];
                    if (!seen_valid) begin
                        check("latency", 64'(cyc - e.acc_cyc), 64'(NCH));
                        seen_valid = 1;
                    end
                    if (out_ready) begin
                        check("S", S, e.s);
                        check("cf", {63'd0, cf}, {63'd0, e.cf});
                        check("zf", {63'd0, zf}, {63'd0, e.zf});
                        check("sf", {63'd0, sf}, {63'd0, e.sf});
                        check("overflow", {63'd0, overflow}, {63'd0, e.ov});
                        void'(exp_q.pop_front());
                        seen_valid = 0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        control   = 2'b00;
        A         = '0;
        B         = '0;
        out_ready = 1'b1;
        #3;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_S", S, 64'd0);
        check("rst_flags", {60'd0, cf, zf, sf, overflow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the Y86 condition-code corners.
        issue(2'b00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue(2'b01, 64'h8000_0000_0000_0000, 64'd1);
        issue(2'b01, 64'd0, 64'd1);
        issue(2'b10, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0);
        issue(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        issue(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        issue(2'b01, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(2'b01, 64'd3, 64'd10);
        n = 0;
        while (!out_valid && n < NCH + 4) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            A = rnd64();
            B = rnd64();
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid_hold", {63'd0, out_valid}, 64'd1);
            check("bp_S_hold", S, 64'hFFFF_FFFF_FFFF_FFF9);
            check("bp_flags_hold", {60'd0, cf, zf, sf, overflow}, {60'd0, 4'b1010});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_back_idle", {63'd0, in_ready}, 64'd1);
        issue(2'b00, 64'd40, 64'd2);
        drain();

        // Reset in the middle of an operation.
        out_ready = 1'b0;
        issue(2'b00, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_S", S, 64'd0);
        check("midrst_flags", {60'd0, cf, zf, sf, overflow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        issue(2'b01, 64'd5, 64'd7);
        drain();

        // Randomized operations with random consumer backpressure.
        rand_bp = 1;
        for (int i = 0; i < 60; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = rnd64();
            b = (i % 5 == 0) ? a : rnd64();
            if (i % 7 == 0) a = {1'b0, {(WIDTH-1){1'b1}}};
            issue(2'($urandom_range(0, 3)), a, b);
        end
        rand_bp = 0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit in case anything stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $finish;
    end

endmodule
